cache_mem_bridge: RTL and testbench
===================================

// Module: cache_mem_bridge
// PURPOSE
//  - Sits between the cache manager and the word-wide main-memory port.
//  - Converts each per-word cache access (ram_en/ram_write/ram_addr, ram_addr offset = block counter)
//    into one req/ack memory transaction and pulses ram_ready once per completed word.
//  - On reads, assembles the returned words into a block register presented as block_out.
//  - On writes, selects the addressed word from the dirty write-back block.
// PARAMETERS
//  OFFSET_WIDTH   3    word-offset bits within a block
//  ADDR_WIDTH     30   word address width
//  DATA_WIDTH     32   word width in bits
//  BLOCK_WIDTH    DATA_WIDTH<<OFFSET_WIDTH   derived block width
//  TIMEOUT_CYCLES 255  watchdog limit in cycles; used only with CACHE_MEM_TIMEOUT_EN
// PORTS
//  clk        in   1            system clock, all state on rising edge
//  rst        in   1            synchronous, active-high reset
//  ram_en     in   1            cache requests a word transfer; held high across a block
//  ram_write  in   1            1 = write-back word, 0 = fill word
//  ram_addr   in   ADDR_WIDTH   word address; low OFFSET_WIDTH bits = word index
//  wb_block   in   BLOCK_WIDTH  dirty block being written back
//  ram_ready  out  1            one-cycle pulse: current word done
//  block_out  out  BLOCK_WIDTH  assembled fill block
//  mem_req    out  1            memory request, held until mem_ack
//  mem_we     out  1            memory write enable
//  mem_addr   out  ADDR_WIDTH   memory word address
//  mem_wdata  out  DATA_WIDTH   memory write data
//  mem_rdata  in   DATA_WIDTH   memory read data, valid with mem_ack
//  mem_ack    in   1            memory completion, single cycle
//  mem_err    out  1            sticky timeout flag; present only with CACHE_MEM_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: state=IDLE. ram_ready, mem_req, mem_we, mem_err = 0. mem_addr, mem_wdata, block_out = 0.
//  - FSM states: IDLE -> REQ -> DONE -> IDLE.
//  - IDLE: when ram_en=1, latch ram_addr and ram_write. If writing, latch wb_block word [offset].
//    Next state is REQ.
//  - REQ: mem_req=1, with mem_we/mem_addr/mem_wdata driven from the latched values.
//    Changes on ram_* inputs are ignored. On mem_ack, go to DONE; if reading, also write mem_rdata
//    into block_out word [offset] on the same edge. mem_ack may arrive in the first REQ cycle.
//  - DONE: ram_ready=1 for exactly one cycle, then IDLE.
//    block_out already contains the new word during this cycle, so the last word of a fill
//    is visible when the cache samples the block.
//  - Minimum latency is 3 cycles per word (IDLE, REQ with immediate ack, DONE); a block takes
//    3*BLOCK_SIZE cycles.
//  - Back-to-back words: the cache advances its counter on ram_ready. The IDLE cycle after DONE
//    therefore latches the next offset. No bubble beyond IDLE is allowed.
//  - ram_en dropped during REQ: the memory transaction still completes (no retraction).
//    DONE is skipped, ram_ready is not pulsed, and the FSM returns to IDLE.
//  - Words of block_out that are not written keep their old values; block_out is cleared only by rst.
//  - mem_ack outside REQ is ignored.
//  - rst mid-transaction aborts immediately (mem_req drops next edge). The memory side
//    must tolerate an abandoned request.
// CONFIGURATION
//  - CACHE_MEM_TIMEOUT_EN defined: an 8+ bit watchdog counts cycles spent in REQ.
//    When it reaches TIMEOUT_CYCLES without mem_ack, the bridge drops mem_req and sets the
//    sticky mem_err (cleared only by rst). On a fill it writes 32'hDEADBEEF into the addressed
//    word, then enters DONE, so the cache never deadlocks.
//  - CACHE_MEM_TIMEOUT_EN not defined: no watchdog and no mem_err port; REQ waits for mem_ack
//    indefinitely.
// STRUCTURE
//  - Shared header mem_bridge.vh, included like status.vh: state encodings MB_IDLE=2'd0,
//    MB_REQ=2'd1, MB_DONE=2'd2, and the timeout fill constant.
//  - One sub-module, block_assembler: the BLOCK_WIDTH register with word-indexed write
//    (enable, offset, data) and word-indexed read mux for wb_block. The FSM stays in
//    cache_mem_bridge.
// TESTING
//  1. Fill: ram_en=1, ram_write=0, addr offsets 0..7, memory acks after 2 cycles returning
//     data = 0x100+offset. Expect 8 ram_ready pulses, and block_out = {0x107..0x100}
//     in the final DONE cycle.
//  2. Write-back: wb_block word i = 0xA0+i, ram_write=1, offsets 0..7.
//     Expect mem_we=1 with mem_wdata=0xA0+i at mem_addr offset i, and 8 ram_ready pulses.
//  3. Zero-wait memory: mem_ack=1 in the first REQ cycle. Expect ram_ready every 3rd cycle
//     and 24 cycles per block.
//  4. ram_en dropped in REQ before ack at offset 3. Expect the ack to be consumed, no
//     ram_ready, the FSM back in IDLE, and word 3 of block_out updated.
//  5. rst asserted for 1 cycle while in REQ. Expect mem_req=0, ram_ready=0, block_out=0 next cycle.
//  6. With CACHE_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack. Expect mem_err=1, one
//     ram_ready pulse, the addressed word = 32'hDEADBEEF, and mem_err held until rst.

Source files
------------

// File: rtl/cache_mem_bridge_pkg.sv
// Shared definitions for the cache/memory bridge: FSM encodings, the timeout fill
// word and the watchdog width helper (used only when CACHE_MEM_TIMEOUT_EN is defined).
package cache_mem_bridge_pkg;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_REQ  = 2'd1,
    MB_DONE = 2'd2
  } mb_state_e;

  localparam logic [31:0] MB_TIMEOUT_FILL = 32'hDEADBEEF;
  localparam int          MB_WDOG_MIN_W   = 8;

  // Watchdog is never narrower than 8 bits, wider only if the limit needs it.
  function automatic int wdog_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < MB_WDOG_MIN_W) ? MB_WDOG_MIN_W : w;
  endfunction

endpackage

// File: rtl/cache_mem_bridge_if.sv
// Word-wide main-memory port (req/ack). mem_err exists only when
// CACHE_MEM_TIMEOUT_EN is defined.
interface cache_mem_bridge_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
`ifdef CACHE_MEM_TIMEOUT_EN
  logic                  mem_err;
`endif

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
`ifdef CACHE_MEM_TIMEOUT_EN
    output mem_err,
`endif
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
`ifdef CACHE_MEM_TIMEOUT_EN
    input  mem_err,
`endif
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_mem_bridge_block_assembler.sv
// Block register with word-indexed write for fills, plus the word-select mux
// that picks the outgoing word from the dirty write-back block.
module cache_mem_bridge_block_assembler #(
  parameter int OFFSET_WIDTH = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_WIDTH  = DATA_WIDTH << OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [OFFSET_WIDTH-1:0] wr_off,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [BLOCK_WIDTH-1:0]  rd_block,
  input  logic [OFFSET_WIDTH-1:0] rd_off,
  output logic [DATA_WIDTH-1:0]   rd_word,
  output logic [BLOCK_WIDTH-1:0]  block
);
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [DATA_WIDTH-1:0] rd_words [WORDS];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;

    // Only the addressed word changes; the rest hold until reset.
    always_comb begin
      word_d = word_q;
      if (wr_en && (wr_off == OFFSET_WIDTH'(gi))) begin
        word_d = wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign block[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    assign rd_words[gi] = rd_block[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rd_word = rd_words[rd_off];

endmodule

// File: rtl/cache_mem_bridge.sv
// Per-word bridge between cache manager and main memory: IDLE -> REQ -> DONE.
// Define CACHE_MEM_TIMEOUT_EN to add the REQ watchdog and the sticky mem_err flag.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int OFFSET_WIDTH   = 3,
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_WIDTH    = DATA_WIDTH << OFFSET_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en,
  input  logic                   ram_write,
  input  logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [BLOCK_WIDTH-1:0] wb_block,
  output logic                   ram_ready,
  output logic [BLOCK_WIDTH-1:0] block_out,
  cache_mem_bridge_if.master     mem
);

  mb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  asm_wr_en;
  logic [DATA_WIDTH-1:0] asm_wr_data;
  logic [DATA_WIDTH-1:0] wb_word;

`ifdef CACHE_MEM_TIMEOUT_EN
  localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              wdog_expired;

  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign mem.mem_err  = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  cache_mem_bridge_block_assembler #(
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_block_assembler (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (asm_wr_en),
    .wr_off  (addr_q[OFFSET_WIDTH-1:0]),
    .wr_data (asm_wr_data),
    .rd_block(wb_block),
    .rd_off  (ram_addr[OFFSET_WIDTH-1:0]),
    .rd_word (wb_word),
    .block   (block_out)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    asm_wr_en   = 1'b0;
    asm_wr_data = mem.mem_rdata;
`ifdef CACHE_MEM_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      MB_IDLE: begin
        if (ram_en) begin
          addr_d  = ram_addr;
          write_d = ram_write;
          if (ram_write) begin
            wdata_d = wb_word;
          end
`ifdef CACHE_MEM_TIMEOUT_EN
          wdog_d  = '0;
`endif
          state_d = MB_REQ;
        end
      end
      MB_REQ: begin
        // A request is never retracted; a dropped ram_en only suppresses DONE.
        if (mem.mem_ack) begin
          asm_wr_en = !write_q;
          state_d   = ram_en ? MB_DONE : MB_IDLE;
        end
`ifdef CACHE_MEM_TIMEOUT_EN
        else if (wdog_expired) begin
          err_d       = 1'b1;
          asm_wr_en   = !write_q;
          asm_wr_data = DATA_WIDTH'(MB_TIMEOUT_FILL);
          state_d     = MB_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      MB_DONE: begin
        state_d = MB_IDLE;
      end
      default: begin
        state_d = MB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MB_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef CACHE_MEM_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
`ifdef CACHE_MEM_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem.mem_req   = (state_q == MB_REQ);
  assign mem.mem_we    = (state_q == MB_REQ) && write_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ram_ready     = (state_q == MB_DONE);

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: table of per-word transfers plus
// hand-written sequences for ram_en drop, stray ack, reset abort and timeout.
module tb_cache_mem_bridge;
  localparam int OW = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW << OW;
`ifdef CACHE_MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam logic [AW-OW-1:0] BASE = 27'h04D2A5C;

  localparam logic [BW-1:0] FILL_EXP = {32'h107, 32'h106, 32'h105, 32'h104,
                                        32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [BW-1:0] ZERO_EXP = {32'h207, 32'h206, 32'h205, 32'h204,
                                        32'h203, 32'h202, 32'h201, 32'h200};

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] wb_block;
  logic          ram_ready;
  logic [BW-1:0] block_out;

  cache_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  cache_mem_bridge #(
    .OFFSET_WIDTH  (OW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BLOCK_WIDTH   (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ram_en   (ram_en),
    .ram_write(ram_write),
    .ram_addr (ram_addr),
    .wb_block (wb_block),
    .ram_ready(ram_ready),
    .block_out(block_out),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle_cnt = 0;
  int ready_cnt = 0;

  always @(negedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (ram_ready === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  typedef struct {
    logic          wr;
    logic [OW-1:0] off;
    int            ack_dly;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_word;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [BW-1:0] blk, input int off);
    return blk[off*DW +: DW];
  endfunction

  // One word: IDLE cycle with ram_en, REQ for 1+ack_dly cycles, DONE, back to IDLE.
  task automatic run_word(input vec_t v, input int idx);
    int c0;
    int r0;
    c0 = cycle_cnt;
    r0 = ready_cnt;
    ram_en    = 1'b1;
    ram_write = v.wr;
    ram_addr  = {BASE, v.off};
    @(posedge clk); #1;
    check($sformatf("v%0d mem_req", idx), BW'(mem.mem_req), BW'(1'b1));
    check($sformatf("v%0d mem_we", idx), BW'(mem.mem_we), BW'(v.wr));
    check($sformatf("v%0d mem_addr", idx), BW'(mem.mem_addr), BW'({BASE, v.off}));
    if (v.wr) check($sformatf("v%0d mem_wdata", idx), BW'(mem.mem_wdata), BW'(v.exp_word));
    for (int k = 0; k < v.ack_dly; k++) begin
      @(posedge clk); #1;
      check($sformatf("v%0d req_hold", idx), BW'(mem.mem_req), BW'(1'b1));
    end
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = v.rdata;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    check($sformatf("v%0d ram_ready", idx), BW'(ram_ready), BW'(1'b1));
    if (!v.wr) check($sformatf("v%0d block_word", idx), BW'(word_of(block_out, int'(v.off))), BW'(v.exp_word));
    @(posedge clk); #1;
    check($sformatf("v%0d ready_drop", idx), BW'(ram_ready), BW'(1'b0));
    check($sformatf("v%0d cycles", idx), BW'(cycle_cnt - c0), BW'(v.exp_cycles));
    check($sformatf("v%0d pulses", idx), BW'(ready_cnt - r0), BW'(1));
    $display("word %0d: wr=%0d off=%0d ack_dly=%0d rdata=%h cycles=%0d", idx, v.wr, v.off,
             v.ack_dly, v.rdata, cycle_cnt - c0);
  endtask

  initial begin
    int c0;
    int r0;
    vec_t extra;

    rst = 1'b1; ram_en = 1'b0; ram_write = 1'b0; ram_addr = '0; wb_block = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;

    for (int i = 0; i < 8; i++) begin
      vecs[i]      = '{wr: 1'b0, off: OW'(i), ack_dly: 2, rdata: DW'(32'h100 + i),
                       exp_word: DW'(32'h100 + i), exp_cycles: 5};
      vecs[8 + i]  = '{wr: 1'b1, off: OW'(i), ack_dly: 1, rdata: DW'(32'h0),
                       exp_word: DW'(32'hA0 + i), exp_cycles: 4};
      vecs[16 + i] = '{wr: 1'b0, off: OW'(i), ack_dly: 0, rdata: DW'(32'h200 + i),
                       exp_word: DW'(32'h200 + i), exp_cycles: 3};
      wb_block[i*DW +: DW] = DW'(32'hA0 + i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ram_ready", BW'(ram_ready), BW'(1'b0));
    check("rst mem_req", BW'(mem.mem_req), BW'(1'b0));
    check("rst mem_we", BW'(mem.mem_we), BW'(1'b0));
    check("rst mem_addr", BW'(mem.mem_addr), BW'(0));
    check("rst mem_wdata", BW'(mem.mem_wdata), BW'(0));
    check("rst block_out", block_out, '0);
`ifdef CACHE_MEM_TIMEOUT_EN
    check("rst mem_err", BW'(mem.mem_err), BW'(1'b0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill with 2-cycle memory latency
    r0 = ready_cnt;
    for (int i = 0; i < 8; i++) run_word(vecs[i], i);
    ram_en = 1'b0;
    check("fill block_out", block_out, FILL_EXP);
    check("fill pulses", BW'(ready_cnt - r0), BW'(8));

    // Write-back leaves the fill block untouched
    for (int i = 8; i < 16; i++) run_word(vecs[i], i);
    ram_en = 1'b0;
    check("wb block_out", block_out, FILL_EXP);

    // Zero-wait memory: 3 cycles per word, 24 per block
    c0 = cycle_cnt;
    r0 = ready_cnt;
    for (int i = 16; i < 24; i++) run_word(vecs[i], i);
    ram_en = 1'b0;
    check("zw block_cycles", BW'(cycle_cnt - c0), BW'(24));
    check("zw pulses", BW'(ready_cnt - r0), BW'(8));
    check("zw block_out", block_out, ZERO_EXP);

    // Stray ack in IDLE is ignored
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h00000BAD;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    check("stray block_out", block_out, ZERO_EXP);
    check("stray mem_req", BW'(mem.mem_req), BW'(1'b0));
    check("stray ram_ready", BW'(ram_ready), BW'(1'b0));
    $display("stray ack: block_out=%h", block_out);

    // ram_en dropped in REQ at offset 3
    r0 = ready_cnt;
    ram_en = 1'b1; ram_write = 1'b0; ram_addr = {BASE, 3'd3};
    @(posedge clk); #1;
    check("drop req", BW'(mem.mem_req), BW'(1'b1));
    ram_en = 1'b0;
    @(posedge clk); #1;
    check("drop req_hold", BW'(mem.mem_req), BW'(1'b1));
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h00000333;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    check("drop ram_ready", BW'(ram_ready), BW'(1'b0));
    check("drop mem_req", BW'(mem.mem_req), BW'(1'b0));
    check("drop word3", BW'(word_of(block_out, 3)), BW'(32'h333));
    check("drop word2", BW'(word_of(block_out, 2)), BW'(32'h202));
    @(posedge clk); #1;
    check("drop ram_ready2", BW'(ram_ready), BW'(1'b0));
    check("drop pulses", BW'(ready_cnt - r0), BW'(0));
    $display("ram_en drop: word3=%h pulses=%0d", word_of(block_out, 3), ready_cnt - r0);
    extra = '{wr: 1'b0, off: 3'd4, ack_dly: 0, rdata: 32'h444, exp_word: 32'h444, exp_cycles: 3};
    run_word(extra, 24);
    ram_en = 1'b0;

    // Reset while in REQ
    ram_en = 1'b1; ram_write = 1'b0; ram_addr = {BASE, 3'd5};
    @(posedge clk); #1;
    check("abort req", BW'(mem.mem_req), BW'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ram_en = 1'b0;
    check("abort mem_req", BW'(mem.mem_req), BW'(1'b0));
    check("abort ram_ready", BW'(ram_ready), BW'(1'b0));
    check("abort block_out", block_out, '0);
    check("abort mem_addr", BW'(mem.mem_addr), BW'(0));
    @(posedge clk); #1;
    check("abort idle", BW'(mem.mem_req), BW'(1'b0));
    $display("reset abort: mem_req=%0d block_out=%h", mem.mem_req, block_out);

`ifdef CACHE_MEM_TIMEOUT_EN
    // Memory never acks: watchdog fills DEADBEEF and raises mem_err
    begin
      bit seen;
      seen = 1'b0;
      r0 = ready_cnt;
      ram_en = 1'b1; ram_write = 1'b0; ram_addr = {BASE, 3'd6};
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk); #1;
        if (ram_ready === 1'b1) seen = 1'b1;
      end
      ram_en = 1'b0;
      check("to ready_seen", BW'(seen), BW'(1'b1));
      check("to mem_err", BW'(mem.mem_err), BW'(1'b1));
      check("to word6", BW'(word_of(block_out, 6)), BW'(32'hDEADBEEF));
      repeat (4) @(posedge clk);
      #1;
      check("to pulses", BW'(ready_cnt - r0), BW'(1));
      check("to err_sticky", BW'(mem.mem_err), BW'(1'b1));
      check("to req_dropped", BW'(mem.mem_req), BW'(1'b0));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("to err_clear", BW'(mem.mem_err), BW'(1'b0));
      $display("timeout: pulses=%0d", ready_cnt - r0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
